// File: rtl/htu_req_arb.sv
// htu_req_arb: shares the single htu_pipe bank-request port among 3 channels.
// Each channel owns a small request FIFO. A round-robin arbiter picks a non-empty
// FIFO whenever the registered output slot can take a new entry. The granted
// channel is stamped into channel_1hot_id so isu responses route back correctly.

package htu_req_arb_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        is_write;
        logic [2:0]  channel_1hot_id;
    } bank_req_t;
endpackage

module htu_req_arb
    import htu_req_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int WBUF_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             ch_req_valid,
    output logic [2:0]             ch_req_ready,
    input  bank_req_t [2:0]        ch_req,
    input  logic [2:0][WBUF_W-1:0] ch_req_wbuf_id,
    output logic                   d_bank_req_valid,
    input  logic                   d_bank_req_ready,
    output bank_req_t              d_bank_req,
    output logic [WBUF_W-1:0]      d_bank_req_wbuf_id,
    output logic [2:0]             d_grant_1hot
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_INC  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // Next index in the 0 -> 1 -> 2 -> 0 round-robin ring.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Per-channel FIFO storage and bookkeeping.
    bank_req_t         mem_req_r  [3][FIFO_DEPTH];
    logic [WBUF_W-1:0] mem_wbuf_r [3][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r   [3];
    logic [PTR_W-1:0]  rd_ptr_r   [3];
    logic [CNT_W-1:0]  cnt_r      [3];

    // Output slot and arbitration history.
    logic              valid_r;
    bank_req_t         req_r;
    logic [WBUF_W-1:0] wbuf_r;
    logic [2:0]        grant_r;
    logic [1:0]        rr_last_r;

    logic [2:0]        full_s;
    logic [2:0]        nonempty_s;
    logic [2:0]        push_s;
    logic [2:0]        pop_s;
    logic              slot_free_s;
    logic              grant_found_s;
    logic [1:0]        grant_idx_s;
    logic              do_grant_s;
    logic [2:0]        grant_1hot_s;
    bank_req_t         head_req_s;
    logic [WBUF_W-1:0] head_wbuf_s;

    // FIFO status: ready depends only on fullness, never on the incoming valid.
    always_comb begin
        full_s     = 3'b000;
        nonempty_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            full_s[i]     = (cnt_r[i] == CNT_FULL);
            nonempty_s[i] = (cnt_r[i] != CNT_ZERO);
        end
        ch_req_ready = ~full_s;
        push_s       = ch_req_valid & ~full_s;
    end

    // Round-robin search starting after the last granted channel.
    always_comb begin
        logic [1:0] cand;
        grant_found_s = 1'b0;
        grant_idx_s   = 2'd0;
        cand          = rr_next(rr_last_r);
        for (int k = 0; k < 3; k++) begin
            if (!grant_found_s && nonempty_s[cand]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand;
            end else begin
                grant_found_s = grant_found_s;
            end
            cand = rr_next(cand);
        end
    end

    // Slot handshake, pop selection and the stamped head payload.
    always_comb begin
        slot_free_s  = !valid_r || d_bank_req_ready;
        do_grant_s   = slot_free_s && grant_found_s;
        grant_1hot_s = 3'b001 << grant_idx_s;
        if (do_grant_s) begin
            pop_s = grant_1hot_s;
        end else begin
            pop_s = 3'b000;
        end
        head_req_s                 = mem_req_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
        head_req_s.channel_1hot_id = grant_1hot_s;
        head_wbuf_s                = mem_wbuf_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
    end

    // FIFO pointers, counts and storage; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                cnt_r[i]    <= CNT_ZERO;
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem_req_r[i][j]  <= '0;
                    mem_wbuf_r[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push_s[i]) begin
                    mem_req_r[i][wr_ptr_r[i]]  <= ch_req[i];
                    mem_wbuf_r[i][wr_ptr_r[i]] <= ch_req_wbuf_id[i];
                    wr_ptr_r[i]                <= wr_ptr_r[i] + PTR_INC;
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_INC;
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CNT_INC;
                    2'b01:   cnt_r[i] <= cnt_r[i] - CNT_INC;
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Output slot: load on grant, empty when nothing pending, hold under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            req_r     <= '0;
            wbuf_r    <= '0;
            grant_r   <= 3'b000;
            rr_last_r <= 2'd2;
        end else if (do_grant_s) begin
            valid_r   <= 1'b1;
            req_r     <= head_req_s;
            wbuf_r    <= head_wbuf_s;
            grant_r   <= grant_1hot_s;
            rr_last_r <= grant_idx_s;
        end else if (slot_free_s) begin
            valid_r <= 1'b0;
            grant_r <= 3'b000;
        end
    end

    assign d_bank_req_valid   = valid_r;
    assign d_bank_req         = req_r;
    assign d_bank_req_wbuf_id = wbuf_r;
    assign d_grant_1hot       = grant_r;

endmodule
